mc_controller: RTL

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mc_controller.sv
// Multicycle ARM-subset control unit: sequences fetch/decode/execute/memory/writeback
// and drives the datapath selects, strobes and ALU operation.
module mc_controller #(
  parameter int unsigned ALUCTRL_W       = 2,
  parameter bit          SKIP_NOWRITE_WB = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:12]         Instr,
  input  logic [3:0]           ALUFlags,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic                 IRWrite,
  output logic                 AdrSrc,
  output logic                 MemReq,
  output logic [1:0]           RegSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [3:0]           State
);

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXECR  = 4'd6;
  localparam logic [3:0] EXECI  = 4'd7;
  localparam logic [3:0] ALUWB  = 4'd8;
  localparam logic [3:0] BRANCH = 4'd9;

  logic [3:0] state_r, next_state_s;
  logic [3:0] flags_r;
  logic       cond_ex_r, cond_ex_s;
  logic [3:0] cond_s, rd_s;
  logic [1:0] op_s;
  logic [5:0] funct_s;
  logic [2:0] alu_code_s;
  logic       no_write_s, is_arith_s, is_cmp_s, exec_s, flag_upd_s;
  logic       pc_write_s, ir_write_s, reg_write_s, mem_write_s, mem_req_s;

  // ARM condition evaluation against {N,Z,C,V}; 1111 never executes
  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    {n, z, c, v} = flags;
    case (cond)
      4'b0000: cond_check = z;
      4'b0001: cond_check = ~z;
      4'b0010: cond_check = c;
      4'b0011: cond_check = ~c;
      4'b0100: cond_check = n;
      4'b0101: cond_check = ~n;
      4'b0110: cond_check = v;
      4'b0111: cond_check = ~v;
      4'b1000: cond_check = c & ~z;
      4'b1001: cond_check = ~c | z;
      4'b1010: cond_check = (n == v);
      4'b1011: cond_check = (n != v);
      4'b1100: cond_check = ~z & (n == v);
      4'b1101: cond_check = z | (n != v);
      4'b1110: cond_check = 1'b1;
      default: cond_check = 1'b0;
    endcase
  endfunction

  assign cond_s    = Instr[31:28];
  assign op_s      = Instr[27:26];
  assign funct_s   = Instr[25:20];
  assign rd_s      = Instr[15:12];
  assign cond_ex_s = cond_check(cond_s, flags_r);
  assign exec_s    = (state_r == EXECR) || (state_r == EXECI);
  assign RegSrc    = {op_s == 2'b01, op_s == 2'b10};
  assign ImmSrc    = op_s;
  assign State     = state_r;

  // ALU command decode; unsupported commands become a non-writing ADD
  always_comb begin
    alu_code_s = 3'd0;
    no_write_s = 1'b0;
    is_arith_s = 1'b0;
    is_cmp_s   = 1'b0;
    case (funct_s[4:1])
      4'b0100: is_arith_s = 1'b1;
      4'b0010: begin alu_code_s = 3'd1; is_arith_s = 1'b1; end
      4'b0000: alu_code_s = 3'd2;
      4'b1100: alu_code_s = 3'd3;
      4'b1010: begin alu_code_s = 3'd1; is_arith_s = 1'b1; no_write_s = 1'b1; is_cmp_s = 1'b1; end
      4'b0001: begin
        if (ALUCTRL_W == 32'd3) alu_code_s = 3'd4;
        else                    no_write_s = 1'b1;
      end
      default: no_write_s = 1'b1;
    endcase
  end

  assign ALUControl = exec_s ? alu_code_s[ALUCTRL_W-1:0] : {ALUCTRL_W{1'b0}};
  assign flag_upd_s = exec_s & cond_ex_r & (funct_s[0] | is_cmp_s);

  // next-state logic
  always_comb begin
    next_state_s = FETCH;
    case (state_r)
      FETCH:  next_state_s = MemReady ? DECODE : FETCH;
      DECODE: begin
        case (op_s)
          2'b00:   next_state_s = funct_s[5] ? EXECI : EXECR;
          2'b01:   next_state_s = MEMADR;
          2'b10:   next_state_s = BRANCH;
          default: next_state_s = FETCH;
        endcase
      end
      MEMADR: next_state_s = funct_s[0] ? MEMRD : MEMWR;
      MEMRD:  next_state_s = MemReady ? MEMWB : MEMRD;
      MEMWR:  next_state_s = (MemReady | ~cond_ex_r) ? FETCH : MEMWR;
      EXECR, EXECI: begin
        if (SKIP_NOWRITE_WB && (no_write_s || !cond_ex_r)) next_state_s = FETCH;
        else                                               next_state_s = ALUWB;
      end
      default: next_state_s = FETCH;
    endcase
  end

  // state, condition latch and flag register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= FETCH;
      flags_r   <= 4'b0000;
      cond_ex_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (state_r == DECODE) cond_ex_r <= cond_ex_s;
      if (flag_upd_s) begin
        flags_r[3:2] <= ALUFlags[3:2];
        if (is_arith_s) flags_r[1:0] <= ALUFlags[1:0];
      end
    end
  end

  // per-state datapath selects and raw strobes
  always_comb begin
    AdrSrc      = 1'b0;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ResultSrc   = 2'b00;
    pc_write_s  = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    mem_write_s = 1'b0;
    mem_req_s   = 1'b0;
    case (state_r)
      FETCH: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        mem_req_s = 1'b1; ir_write_s = MemReady; pc_write_s = MemReady;
      end
      DECODE: begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10; end
      MEMADR: ALUSrcB = 2'b01;
      MEMRD:  begin AdrSrc = 1'b1; mem_req_s = 1'b1; end
      MEMWB: begin
        ResultSrc   = 2'b01;
        reg_write_s = cond_ex_r;
        pc_write_s  = cond_ex_r & (rd_s == 4'hF);
      end
      MEMWR: begin AdrSrc = 1'b1; mem_req_s = cond_ex_r; mem_write_s = cond_ex_r; end
      EXECI:  ALUSrcB = 2'b01;
      ALUWB: begin
        reg_write_s = cond_ex_r & ~no_write_s;
        pc_write_s  = cond_ex_r & ~no_write_s & (rd_s == 4'hF);
      end
      BRANCH: begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; ResultSrc = 2'b10; pc_write_s = cond_ex_r; end
      default: ALUSrcA = 2'b00;
    endcase
  end

  assign PCWrite  = pc_write_s  & ~reset;
  assign IRWrite  = ir_write_s  & ~reset;
  assign RegWrite = reg_write_s & ~reset;
  assign MemWrite = mem_write_s & ~reset;
  assign MemReq   = mem_req_s   & ~reset;

endmodule
